// File: rtl/he_decode_pkg.sv
// ============================================================================
// he_decode_pkg : shared sizes and state encoding for the BFV message decoder
// Revision 1.0
// ============================================================================
`default_nettype none

package he_decode_pkg;

    localparam int N       = 1024;
    localparam int COEFF_W = 30;
    localparam int LOG_N   = 10;
    localparam int CMP_W   = COEFF_W + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/decode_round_bit.sv
// ============================================================================
// decode_round_bit : combinational round(2c/q) mod 2 for one coefficient
// Revision 1.0
// ============================================================================
`default_nettype none

module decode_round_bit
    import he_decode_pkg::*;
(
    input  logic [COEFF_W-1:0] c,
    input  logic [COEFF_W-1:0] q,
    output logic               msg_bit,
    output logic               out_of_range
);

    logic [CMP_W-1:0] c4;
    logic [CMP_W-1:0] q1;
    logic [CMP_W-1:0] q3;

    // 4c and 3q both fit in two extra bits, so the window test never overflows
    assign c4 = {c, 2'b00};
    assign q1 = {2'b00, q};
    assign q3 = q1 + {1'b0, q, 1'b0};

    assign out_of_range = (c >= q);
    assign msg_bit      = !out_of_range && (c4 >= q1) && (c4 < q3);

endmodule

`default_nettype wire

// File: rtl/message_decode.sv
// ============================================================================
// message_decode : serial coefficient-to-bit decoder assembling an N-bit message
// Revision 1.0
// ============================================================================
`default_nettype none

module message_decode
    import he_decode_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COEFF_W-1:0] q,
    input  logic [COEFF_W-1:0] coeff_in,
    input  logic               coeff_valid,
    output logic               coeff_ready,
    output logic [N-1:0]       message,
    output logic               msg_valid,
    output logic               done,
    output logic               err
);

    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

    state_t             state;
    state_t             next_state;
    logic [COEFF_W-1:0] q_r;
    logic [LOG_N-1:0]   count;
    logic               accept;
    logic               dec_bit;
    logic               dec_oor;
    logic               s_bit;
    logic [LOG_N-1:0]   s_idx;
    logic               s_vld;

    decode_round_bit u_round (
        .c            (coeff_in),
        .q            (q_r),
        .msg_bit      (dec_bit),
        .out_of_range (dec_oor)
    );

    assign accept = coeff_valid && (state == COLLECT);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        coeff_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = COLLECT;
            end
            COLLECT: begin
                coeff_ready = 1'b1;
                if (coeff_valid && (count == LAST_IDX)) next_state = DRAIN;
            end
            DRAIN: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r       <= '0;
            count     <= '0;
            message   <= '0;
            msg_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            s_bit     <= 1'b0;
            s_idx     <= '0;
            s_vld     <= 1'b0;
        end else begin
            done  <= 1'b0;
            s_vld <= 1'b0;
            // One-cycle stage write-back; the final bit lands during DRAIN
            if (s_vld) message[s_idx] <= s_bit;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_r       <= q;
                        message   <= '0;
                        msg_valid <= 1'b0;
                        err       <= (q < COEFF_W'(2));
                        count     <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        s_bit <= dec_bit;
                        s_idx <= count;
                        s_vld <= 1'b1;
                        count <= count + LOG_N'(1);
                        if (dec_oor) err <= 1'b1;
                    end
                end
                DRAIN: begin
                    done      <= 1'b1;
                    msg_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_message_decode.sv
// ============================================================================
// tb_message_decode : directed self-checking bench for message_decode
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_message_decode;
    import he_decode_pkg::*;

    localparam logic [COEFF_W-1:0] QBIG  = 30'd1073479681;
    localparam logic [COEFF_W-1:0] DELTA = QBIG >> 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [COEFF_W-1:0] q;
    logic [COEFF_W-1:0] coeff_in;
    logic               coeff_valid;
    logic               coeff_ready;
    logic [N-1:0]       message;
    logic               msg_valid;
    logic               done;
    logic               err;

    logic [COEFF_W-1:0] mem [N];
    logic [N-1:0]       exp_msg;
    int                 checks = 0;
    int                 errors = 0;
    longint             cyc = 0;
    longint             start_cyc, last_acc, done_cyc;
    int                 ready_cnt = 0;
    int                 done_cnt = 0;
    int                 r0, d0;

    message_decode dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .q           (q),
        .coeff_in    (coeff_in),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .message     (message),
        .msg_valid   (msg_valid),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (coeff_ready) ready_cnt <= ready_cnt + 1;
        if (done)        done_cnt  <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Encoder model: bit k of the repeated byte scaled by Delta plus small noise mod q
    task automatic fill_pattern(input logic [7:0] pat);
        for (int k = 0; k < N; k++) begin
            longint v;
            int nz;
            nz = int'($urandom_range(0, 2000)) - 1000;
            v  = (pat[k % 8] ? longint'(DELTA) : 0) + nz;
            if (v < 0) v += longint'(QBIG);
            mem[k]     = COEFF_W'(v);
            exp_msg[k] = pat[k % 8];
        end
    endtask

    task automatic fill_const(input logic [COEFF_W-1:0] c);
        for (int k = 0; k < N; k++) mem[k] = c;
    endtask

    task automatic start_decode(input logic [COEFF_W-1:0] qv);
        start     = 1'b1;
        q         = qv;
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic feed(input bit gaps, input bit hold_start, input int stop_at);
        int idx = 0;
        int budget = 0;
        while (idx < stop_at && budget < 8 * N) begin
            coeff_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            coeff_in    = mem[idx];
            if (hold_start) begin
                start = 1'b1;
                q     = 30'd3;
            end
            if (coeff_valid && coeff_ready) begin
                last_acc = cyc;
                idx++;
            end
            @(negedge clk);
            budget++;
        end
        coeff_valid = 1'b0;
        check("feed_accepts", N'(idx), N'(stop_at));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", N'(done), N'(1));
        done_cyc = cyc;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; q = '0; coeff_in = '0; coeff_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_message", message, '0);
        check("rst_flags", N'({msg_valid, done, err, coeff_ready}), '0);
        reset = 1'b0;
        @(negedge clk);

        // Rounding thresholds around q/4 and 3q/4, plus an out-of-range entry
        fill_const('0);
        mem[0] = 30'd0;   mem[1] = 30'd249; mem[2] = 30'd250; mem[3] = 30'd500;
        mem[4] = 30'd749; mem[5] = 30'd750; mem[6] = 30'd999; mem[7] = 30'd1000;
        start_decode(30'd1000);
        feed(1'b0, 1'b0, N);
        wait_done();
        check("thr_message", message, N'(8'h1C));
        check("thr_err", N'(err), N'(1));
        check("thr_valid", N'(msg_valid), N'(1));
        @(negedge clk);
        check("thr_done_pulse", N'(done), N'(0));

        // Round trip with latency and throughput checks
        fill_pattern(8'hA5);
        r0 = ready_cnt; d0 = done_cnt;
        start_decode(QBIG);
        feed(1'b0, 1'b0, N);
        wait_done();
        check("rt_message", message, exp_msg);
        check("rt_err", N'(err), N'(0));
        check("rt_acc_to_done", N'(done_cyc - last_acc), N'(2));
        check("rt_start_to_done", N'(done_cyc - start_cyc + 1), N'(N + 3));
        @(negedge clk);
        check("rt_ready_cycles", N'(ready_cnt - r0), N'(N));
        check("rt_done_pulses", N'(done_cnt - d0), N'(1));

        // Random valid gaps, every coefficient at 3q/8
        fill_const(30'd300);
        start_decode(30'd800);
        feed(1'b1, 1'b0, N);
        wait_done();
        check("bp_message", message, '1);
        check("bp_err", N'(err), N'(0));
        @(negedge clk);

        // start held through COLLECT/DRAIN with a bogus q, then restart in done cycle
        fill_const(30'd500);
        start_decode(30'd1000);
        feed(1'b0, 1'b1, N);
        start = 1'b1; q = 30'd3;
        @(negedge clk);
        check("ign_done", N'(done), N'(1));
        check("ign_message", message, '1);
        check("ign_err", N'(err), N'(0));
        check("ign_valid", N'(msg_valid), N'(1));
        start = 1'b1; q = 30'd1000;
        @(negedge clk);
        start = 1'b0;
        check("restart_valid", N'(msg_valid), N'(0));
        check("restart_ready", N'(coeff_ready), N'(1));
        check("restart_message", message, '0);

        // Reset after 500 accepts aborts the decode
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start_decode(30'd1000);
        feed(1'b0, 1'b0, 500);
        reset = 1'b1;
        @(negedge clk);
        check("abort_message", message, '0);
        check("abort_flags", N'({msg_valid, coeff_ready, err}), '0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle", N'(coeff_ready), N'(0));

        // Fresh full decode after the abort
        fill_pattern(8'h3C);
        start_decode(QBIG);
        feed(1'b0, 1'b0, N);
        wait_done();
        check("fresh_message", message, exp_msg);
        check("fresh_err", N'(err), N'(0));
        check("fresh_valid", N'(msg_valid), N'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
